// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: shared definitions for the IF/ID elastic buffer.
//  - XLEN       datapath width for pc/instr
//  - NOP_INS    word presented on out_instr when the buffer is empty
//  - if_id_entry_t  one buffered beat {pc, instr, pc_plus4}
//  - if_id_cnt_e    occupancy state (EMPTY/ONE/FULL)
package if_id_buffer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } if_id_cnt_e;

endpackage

// File: rtl/if_id_slot.sv
// if_id_slot: one storage entry of the IF/ID buffer.
//  clk     in  clock, rising edge
//  reset   in  synchronous active-high clear (zeroes the entry)
//  i_ld    in  load i_d on this edge
//  i_d     in  entry to store
//  o_q     out stored entry
module if_id_slot
  import if_id_buffer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ld,
  input  if_id_entry_t i_d,
  output if_id_entry_t o_q
);

  if_id_entry_t r_q;

  always_ff @(posedge clk) begin
    if (reset)     r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic buffer between fetch and decode.
//  Captures {pc, instr, pc+4} on push, presents the oldest beat to decode
//  with valid/ready, back-pressures fetch through a registered in_ready,
//  and drops everything on flush. No combinational input-to-output path.
//  Ports:
//   clk, reset (sync, active-high)
//   pc_in, instr_in, in_valid / in_ready   fetch side
//   flush                                  redirect: discard all beats
//   out_valid / out_ready, out_pc, out_instr, out_pc_plus4   decode side
//  Optional build macro IF_ID_BUFFER_PERF_EN adds perf_stall_cnt and
//  perf_flush_cnt outputs (wrapping 32-bit counters, cleared by reset).
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_plus4
`ifdef IF_ID_BUFFER_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  if_id_cnt_e   r_state, w_state_nxt;
  logic         r_head, r_tail;
  logic         r_in_ready;
  logic         w_push, w_pop;
  if_id_entry_t w_new;
  if_id_entry_t w_slot_q [2];
  if_id_entry_t w_head;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_state != EMPTY) & out_ready;

  assign w_new.pc       = pc_in;
  assign w_new.instr    = instr_in;
  assign w_new.pc_plus4 = pc_in + XLEN'(4);  // wraps mod 2^XLEN

  // Occupancy FSM; flush overrides any push/pop this cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_push) w_state_nxt = ONE;
      ONE:     if (w_push & ~w_pop) w_state_nxt = FULL;
               else if (w_pop & ~w_push) w_state_nxt = EMPTY;
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
      if (flush) begin
        r_head <= 1'b0;
        r_tail <= 1'b0;
      end else begin
        if (w_push) r_tail <= ~r_tail;
        if (w_pop)  r_head <= ~r_head;
      end
    end
  end

  // Storage is only zeroed by reset; a flush just forgets the contents.
  for (genvar g = 0; g < 2; g++) begin : g_slot
    if_id_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .i_ld  (w_push & ~flush & (r_tail == 1'(g))),
      .i_d   (w_new),
      .o_q   (w_slot_q[g])
    );
  end

  assign w_head       = w_slot_q[r_head];
  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state != EMPTY);
  assign out_pc       = w_head.pc;
  assign out_pc_plus4 = w_head.pc_plus4;
  assign out_instr    = out_valid ? w_head.instr : NOP_INS;

`ifdef IF_ID_BUFFER_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (in_valid & ~r_in_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)                  r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed + randomized bench for if_id_buffer.
// Reference model is a plain queue of accepted beats; in_ready is the
// queue having room, the head is the queue front.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] pc_in, instr_in;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr, out_pc_plus4;
`ifdef IF_ID_BUFFER_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_pc [$];
  logic [31:0] q_ins[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  logic        last_reset = 1'b0;
  bit          seen_20 = 1'b0;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .instr_in     (instr_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_pc_plus4 (out_pc_plus4)
`ifdef IF_ID_BUFFER_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with the queue model.
  task automatic check_model();
    chk("in_ready", {31'd0, in_ready}, {31'd0, q_pc.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q_pc.size() != 0});
    if (q_pc.size() != 0) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_instr", out_instr, q_ins[0]);
      chk("out_pc_plus4", out_pc_plus4, q_pc[0] + 32'd4);
    end else begin
      chk("out_instr_nop", out_instr, NOP);
    end
    if (last_reset) begin
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);
    end
`ifdef IF_ID_BUFFER_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_stall);
    chk("perf_flush", perf_flush_cnt, m_flush);
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic r, input logic v, input logic fl, input logic ordy,
                      input logic [31:0] pc, input logic [31:0] ins);
    bit room, push, pop;
    reset = r; in_valid = v; flush = fl; out_ready = ordy; pc_in = pc; instr_in = ins;
    @(posedge clk);
    room = (q_pc.size() < 2);
    if (r) begin
      q_pc.delete(); q_ins.delete();
      m_stall = 0; m_flush = 0;
    end else begin
      if (v && !room) m_stall++;
      if (fl) m_flush++;
      if (fl) begin
        q_pc.delete(); q_ins.delete();
      end else begin
        push = v && room;
        pop  = (q_pc.size() != 0) && ordy;
        if (pop) begin void'(q_pc.pop_front()); void'(q_ins.pop_front()); end
        if (push) begin q_pc.push_back(pc); q_ins.push_back(ins); end
      end
    end
    last_reset = r;
    #1;
    if (out_valid && out_pc == 32'h20) seen_20 = 1'b1;
    check_model();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in = '0; instr_in = '0;

    // Reset held two cycles
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_instr", out_instr, NOP);

    // Single beat, one cycle latency, then drains
    step(0, 1, 0, 1, 32'h100, 32'h0050_0093);
    chk("single_pc", out_pc, 32'h100);
    chk("single_pc4", out_pc_plus4, 32'h104);
    chk("single_instr", out_instr, 32'h0050_0093);
    step(0, 0, 0, 1, 0, 0);
    chk("single_empty", {31'd0, out_valid}, 32'd0);

    // Back-pressure: 0x8 held off until a pop, order 0x0,0x4,0x8
    step(0, 1, 0, 0, 32'h0, 32'hA0);
    step(0, 1, 0, 0, 32'h4, 32'hA4);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step(0, 1, 0, 0, 32'h8, 32'hA8);
    chk("bp_head0", out_pc, 32'h0);
    step(0, 1, 0, 1, 32'h8, 32'hA8);   // pops 0x0, 0x8 refused (FULL)
    chk("bp_head4", out_pc, 32'h4);
    step(0, 1, 0, 1, 32'h8, 32'hA8);   // pops 0x4, accepts 0x8
    chk("bp_head8", out_pc, 32'h8);
    step(0, 0, 0, 1, 0, 0);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush in FULL with a beat presented at the same time
    step(0, 1, 0, 0, 32'h10, 32'hB0);
    step(0, 1, 0, 0, 32'h14, 32'hB4);
    step(0, 1, 1, 0, 32'h20, 32'hB8);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_no_20", {31'd0, seen_20}, 32'd0);

    // pc+4 wraps
    step(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h1234_5678);
    chk("wrap_pc4", out_pc_plus4, 32'h0);
    step(0, 0, 0, 1, 0, 0);

    // Reset mid-operation clears storage; reset beats a simultaneous flush
    step(0, 1, 0, 0, 32'h40, 32'hC0);
    step(0, 1, 0, 0, 32'h44, 32'hC4);
    step(1, 1, 1, 1, 32'h48, 32'hC8);

`ifdef IF_ID_BUFFER_PERF_EN
    // 3 stalled cycles + 2 flush cycles, then reset clears both
    step(0, 1, 0, 0, 32'h50, 1);
    step(0, 1, 0, 0, 32'h54, 2);
    step(0, 1, 0, 0, 32'h58, 3);
    step(0, 1, 0, 0, 32'h58, 3);
    step(0, 1, 0, 0, 32'h58, 3);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("perf_stall3", perf_stall_cnt, 32'd3);
    chk("perf_flush2", perf_flush_cnt, 32'd2);
    step(1, 0, 0, 0, 0, 0);
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      logic r, v, fl, ordy;
      r    = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(r, v, fl, ordy, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
